// File: rtl/vproc_pkg.sv
// Shared vector-processor constants, types and helpers.
package vproc_pkg;

  localparam int unsigned VREG_CNT    = 32;
  localparam int unsigned VREG_ADDR_W = 5;
  localparam int unsigned VREG_PORT_W = 128;

  // Register file write request at default widths; modules built with other
  // widths declare a local struct of the same shape.
  typedef struct packed {
    logic [VREG_ADDR_W-1:0]   addr;
    logic [VREG_PORT_W-1:0]   data;
    logic [VREG_PORT_W/8-1:0] be;
  } vreg_wr_req_t;

  // Index width for a count; at least one bit so single-entry cases stay legal.
  function automatic int unsigned idx_width(input int unsigned cnt);
    if (cnt > 1) begin
      return $clog2(cnt);
    end
    return 1;
  endfunction

endpackage

// File: rtl/vproc_wr_port_alloc.sv
// Combinational round-robin allocator of register file write ports to writer
// units. Requesters are scanned from rr_ptr_i; each valid one takes the lowest
// free port unless its address is already granted in this scan.
module vproc_wr_port_alloc
  import vproc_pkg::*;
#(
  parameter int unsigned REQ_CNT     = 4,
  parameter int unsigned PORT_WR_CNT = 2,
  parameter int unsigned MAX_ADDR_W  = 5,
  parameter int unsigned IDX_W       = idx_width(REQ_CNT)
) (
  input  logic [REQ_CNT-1:0]                    valid_i,
  input  logic [REQ_CNT-1:0][MAX_ADDR_W-1:0]    addr_i,
  input  logic [IDX_W-1:0]                      rr_ptr_i,
  // avail_o[r]: r would be granted if it were valid (independent of valid_i[r])
  output logic [REQ_CNT-1:0]                    avail_o,
  output logic [REQ_CNT-1:0]                    grant_o,
  output logic [PORT_WR_CNT-1:0][REQ_CNT-1:0]   port_sel_o,
  output logic [IDX_W-1:0]                      last_idx_o
);

  // Scan requesters in round-robin order and hand out ports
  always_comb begin
    int unsigned      taken;
    int unsigned      scan;
    logic [IDX_W-1:0] r;
    logic             clash;

    avail_o    = '0;
    grant_o    = '0;
    port_sel_o = '0;
    last_idx_o = '0;
    taken      = 0;
    scan       = 0;
    r          = '0;
    clash      = 1'b0;

    for (int unsigned k = 0; k < REQ_CNT; k++) begin
      scan = 32'(rr_ptr_i) + k;
      if (scan >= REQ_CNT) begin
        scan = scan - REQ_CNT;
      end
      r = scan[IDX_W-1:0];

      // Only requesters granted earlier in this scan can block r.
      clash = 1'b0;
      for (int unsigned j = 0; j < REQ_CNT; j++) begin
        if (grant_o[j] && (addr_i[j] == addr_i[r])) begin
          clash = 1'b1;
        end
      end

      if ((taken < PORT_WR_CNT) && !clash) begin
        avail_o[r] = 1'b1;
        if (valid_i[r]) begin
          for (int unsigned p = 0; p < PORT_WR_CNT; p++) begin
            if (p == taken) begin
              port_sel_o[p][r] = 1'b1;
            end
          end
          grant_o[r] = 1'b1;
          last_idx_o = r;
          taken      = taken + 1;
        end
      end
    end
  end

endmodule

// File: rtl/vproc_vreg_wr_arbiter.sv
// Vector register file write-port arbiter: shares PORT_WR_CNT write ports among
// REQ_CNT writer units with round-robin allocation and one registered stage.
// Never issues two writes to the same vreg in one cycle.
module vproc_vreg_wr_arbiter
  import vproc_pkg::*;
#(
  parameter int unsigned REQ_CNT     = 4,
  parameter int unsigned PORT_WR_CNT = 2,
  parameter int unsigned MAX_PORT_W  = 128,
  parameter int unsigned MAX_ADDR_W  = 5
) (
  input  logic                                      clk_i,
  input  logic                                      async_rst_i,
  input  logic                                      stall_i,
  input  logic [REQ_CNT-1:0]                        req_valid_i,
  output logic [REQ_CNT-1:0]                        req_ready_o,
  input  logic [REQ_CNT-1:0][MAX_ADDR_W-1:0]        req_addr_i,
  input  logic [REQ_CNT-1:0][MAX_PORT_W-1:0]        req_data_i,
  input  logic [REQ_CNT-1:0][MAX_PORT_W/8-1:0]      req_be_i,
  output logic [PORT_WR_CNT-1:0]                    wr_we_o,
  output logic [PORT_WR_CNT-1:0][MAX_ADDR_W-1:0]    wr_addr_o,
  output logic [PORT_WR_CNT-1:0][MAX_PORT_W-1:0]    wr_data_o,
  output logic [PORT_WR_CNT-1:0][MAX_PORT_W/8-1:0]  wr_be_o,
  output logic [VREG_CNT-1:0]                       wr_pend_o
);

  localparam int unsigned IDX_W = idx_width(REQ_CNT);
  localparam int unsigned BE_W  = MAX_PORT_W / 8;

  typedef struct packed {
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_PORT_W-1:0] data;
    logic [BE_W-1:0]       be;
  } port_req_t;

  logic [IDX_W-1:0]                    rr_ptr_q, rr_ptr_d;
  logic [REQ_CNT-1:0]                  avail;
  logic [REQ_CNT-1:0]                  grant;
  logic [PORT_WR_CNT-1:0][REQ_CNT-1:0] port_sel;
  logic [IDX_W-1:0]                    last_idx;
  port_req_t [REQ_CNT-1:0]             req_in;
  port_req_t [PORT_WR_CNT-1:0]         port_d, port_q;
  logic [PORT_WR_CNT-1:0]              we_d, we_q;

  vproc_wr_port_alloc #(
    .REQ_CNT     (REQ_CNT),
    .PORT_WR_CNT (PORT_WR_CNT),
    .MAX_ADDR_W  (MAX_ADDR_W),
    .IDX_W       (IDX_W)
  ) u_alloc (
    .valid_i    (req_valid_i),
    .addr_i     (req_addr_i),
    .rr_ptr_i   (rr_ptr_q),
    .avail_o    (avail),
    .grant_o    (grant),
    .port_sel_o (port_sel),
    .last_idx_o (last_idx)
  );

  // A stalled register file accepts nothing, so ready is masked as a whole.
  assign req_ready_o = avail & {REQ_CNT{~stall_i}};

  // Bundle each requester's fields for the per-port muxes
  always_comb begin
    for (int unsigned r = 0; r < REQ_CNT; r++) begin
      req_in[r] = {req_addr_i[r], req_data_i[r], req_be_i[r]};
    end
  end

  // Round-robin pointer advances past the last requester granted this cycle
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (!stall_i && (|grant)) begin
      if (32'(last_idx) == REQ_CNT - 1) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = last_idx + IDX_W'(1);
      end
    end
  end

  // Per-port one-hot mux from the granted requester
  always_comb begin
    for (int unsigned p = 0; p < PORT_WR_CNT; p++) begin
      port_d[p] = '0;
      for (int unsigned r = 0; r < REQ_CNT; r++) begin
        if (port_sel[p][r]) begin
          port_d[p] = req_in[r];
        end
      end
      we_d[p] = (|port_sel[p]) & ~stall_i;
    end
  end

  // Pointer and output stage; idle ports hold their payload to avoid toggling
  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      rr_ptr_q <= '0;
      we_q     <= '0;
      port_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      for (int unsigned p = 0; p < PORT_WR_CNT; p++) begin
        if (we_d[p]) begin
          port_q[p] <= port_d[p];
        end
      end
    end
  end

  assign wr_we_o = we_q;

  // Unpack the output registers onto the register file ports
  always_comb begin
    for (int unsigned p = 0; p < PORT_WR_CNT; p++) begin
      wr_addr_o[p] = port_q[p].addr;
      wr_data_o[p] = port_q[p].data;
      wr_be_o[p]   = port_q[p].be;
    end
  end

  // Decode the vregs currently being written into a pending mask
  always_comb begin
    wr_pend_o = '0;
    for (int unsigned p = 0; p < PORT_WR_CNT; p++) begin
      if (we_q[p]) begin
        wr_pend_o[port_q[p].addr] = 1'b1;
      end
    end
  end

endmodule
